// File: rtl/opcap_pkg.sv
// Shared definitions for the operand capture front-end.
//   state_e                 : capture FSM states (2-bit encoding)
//   W_OP_DEFAULT            : default operand width
//   DEBOUNCE_CYCLES_DEFAULT : default debounce length (10 ms at 50 MHz)
package opcap_pkg;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    localparam int unsigned W_OP_DEFAULT            = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/operand_capture_if.sv
// Operand bus between the capture front-end and the multiplier.
//   op_bus   : packed operands, A in the low W_OP bits, B in the high W_OP bits
//   op_valid : op_bus holds a complete A/B pair
//   op_ready : consumer accepts op_bus when op_valid & op_ready
// Modports: master (producer side), slave (consumer side).
interface operand_capture_if
    import opcap_pkg::*;
#(
    parameter int unsigned W_OP = W_OP_DEFAULT
);

    logic [2*W_OP-1:0] op_bus;
    logic              op_valid;
    logic              op_ready;

    modport master (output op_bus, output op_valid, input op_ready);
    modport slave  (input op_bus, input op_valid, output op_ready);

endinterface

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debounce counter and
// a registered one-cycle pulse on each debounced press (released -> pressed).
// Build option: OPCAP_DEBOUNCE_EN enables the counter; without it the
// synchronized key is used directly and DEBOUNCE_CYCLES is ignored.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   key         : raw pushbutton, active-low
//   press_pulse : one-cycle pulse per accepted press
module key_debounce
    import opcap_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press_pulse
);

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1_q, sync2_q;
    logic level_q, level_d;
    logic press_q;

    // Synchronizer resets to "released" so a key held through reset still
    // produces a clean falling transition afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

`ifdef OPCAP_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; any agreement restarts.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
`else
    // Level is the synchronized key; its next value is the first flop.
    assign level_q = sync2_q;
    assign level_d = sync1_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_q <= 1'b0;
        end else begin
            press_q <= level_q & ~level_d;
        end
    end

    assign press_pulse = press_q;

endmodule

// File: rtl/operand_capture.sv
// Captures operand A then B from SW on successive debounced KEY presses and
// presents them on a packed valid/ready bus whose layout matches the
// multiplier's SW[3:0] input.
// Build option: OPCAP_DEBOUNCE_EN (passed through to key_debounce).
//   CLOCK_50 : system clock
//   reset    : asynchronous active-high reset
//   SW       : operand value to capture
//   KEY      : pushbutton, active-low
//   LEDG     : [0] A loaded, [1] B loaded
//   bus      : operand bus (master side): op_bus, op_valid, op_ready
module operand_capture
    import opcap_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned W_OP            = W_OP_DEFAULT
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [W_OP-1:0] SW,
    input  logic            KEY,
    output logic [1:0]      LEDG,
    operand_capture_if.master bus
);

    logic            press;
    state_e          state_q, state_d;
    logic [W_OP-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]      ledg_q, ledg_d;
    logic            valid_q;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk        (CLOCK_50),
        .rst        (reset),
        .key        (KEY),
        .press_pulse(press)
    );

    // Presses while presenting fall through unhandled, so they are dropped.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ledg_d  = ledg_q;
        unique case (state_q)
            WAIT_A: begin
                if (press) begin
                    a_d       = SW;
                    ledg_d[0] = 1'b1;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press) begin
                    b_d       = SW;
                    ledg_d[1] = 1'b1;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (valid_q && bus.op_ready) begin
                    ledg_d  = '0;
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            ledg_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ledg_q  <= ledg_d;
            valid_q <= (state_d == PRESENT);
        end
    end

    assign bus.op_bus   = {b_q, a_q};
    assign bus.op_valid = valid_q;
    assign LEDG         = ledg_q;

endmodule

// File: tb/tb_operand_capture.sv
// Self-checking bench for operand_capture (DEBOUNCE_CYCLES = 4). A reference
// model built from the behavioural rules (a press is accepted once the key has
// been seen opposite to the accepted level for a full window of samples) is
// compared against the DUT outputs on every falling clock edge.
module tb_operand_capture;

    localparam int unsigned DC = 4;
    localparam int unsigned W  = 2;
`ifdef OPCAP_DEBOUNCE_EN
    localparam int unsigned WinLen = DC;
    localparam int unsigned WinLag = 2;
`else
    localparam int unsigned WinLen = 1;
    localparam int unsigned WinLag = 1;
`endif
    // Edges from the first low sample to the capturing edge.
    localparam int unsigned CapLat  = WinLen + WinLag + 1;
    localparam int unsigned HistLen = WinLen + WinLag + 1;

    logic         CLOCK_50 = 1'b0;
    logic         reset    = 1'b0;
    logic [W-1:0] SW       = '0;
    logic         KEY      = 1'b1;
    logic [1:0]   LEDG;

    operand_capture_if #(.W_OP(W)) opif ();

    operand_capture #(
        .DEBOUNCE_CYCLES(DC),
        .W_OP           (W)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .SW      (SW),
        .KEY     (KEY),
        .LEDG    (LEDG),
        .bus     (opif)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 = loading A, 1 = loading B, 2 = presenting.
    int           m_mode;
    logic [W-1:0] m_a, m_b;
    logic         m_level;
    logic         m_press;
    logic         m_hist [HistLen];

    function automatic void m_clear();
        m_mode  = 0;
        m_a     = '0;
        m_b     = '0;
        m_level = 1'b1;
        m_press = 1'b0;
        for (int i = 0; i < HistLen; i++) m_hist[i] = 1'b1;
    endfunction

    function automatic void m_step();
        logic flip;
        case (m_mode)
            0: if (m_press) begin m_a = SW; m_mode = 1; end
            1: if (m_press) begin m_b = SW; m_mode = 2; end
            default: if (opif.op_ready) m_mode = 0;
        endcase
        for (int i = HistLen - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = KEY;
        flip = 1'b1;
        for (int i = WinLag; i < WinLag + WinLen; i++)
            if (m_hist[i] == m_level) flip = 1'b0;
        m_press = 1'b0;
        if (flip) begin
            m_level = ~m_level;
            m_press = ~m_level;
        end
    endfunction

    task automatic compare_all();
        logic [1:0] exp_ledg;
        exp_ledg = (m_mode == 0) ? 2'b00 : (m_mode == 1) ? 2'b01 : 2'b11;
        check_eq("op_bus", 32'(opif.op_bus), 32'({m_b, m_a}));
        check_eq("op_valid", 32'(opif.op_valid), 32'(m_mode == 2));
        check_eq("ledg", 32'(LEDG), 32'(exp_ledg));
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        m_step();
        @(negedge CLOCK_50);
        compare_all();
    endtask

    task automatic press(input int low_cycles, input int high_cycles);
        KEY = 1'b0;
        repeat (low_cycles) tick();
        KEY = 1'b1;
        repeat (high_cycles) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_op_bus"}, 32'(opif.op_bus), 32'd0);
        check_eq({tag, "_op_valid"}, 32'(opif.op_valid), 32'd0);
        check_eq({tag, "_ledg"}, 32'(LEDG), 32'd0);
    endtask

    initial begin
        int lat;
        int run;
        opif.op_ready = 1'b0;
        m_clear();

        // Power-on reset.
        #1 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge CLOCK_50);
        check_reset_outputs("por_hold");
        reset = 1'b0;
        tick();

        // Basic load: A = 2'b10 with latency measurement, then B = 2'b11.
        SW  = 2'b10;
        KEY = 1'b0;
        lat = 0;
        for (int i = 1; i <= int'(CapLat) + 4; i++) begin
            tick();
            if (LEDG[0] && lat == 0) lat = i;
        end
        check_eq("lat_a", 32'(lat), 32'(CapLat));
        KEY = 1'b1;
        repeat (CapLat + 2) tick();
        check_eq("load_a_ledg", 32'(LEDG), 32'b01);
        SW = 2'b11;
        press(CapLat + 2, CapLat + 2);
        check_eq("load_b_bus", 32'(opif.op_bus), 32'b1110);
        check_eq("load_b_valid", 32'(opif.op_valid), 32'd1);
        check_eq("load_b_ledg", 32'(LEDG), 32'b11);

        // Handshake with ready held low, plus an ignored press.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_valid", 32'(opif.op_valid), 32'd1);
            check_eq("hold_bus", 32'(opif.op_bus), 32'b1110);
        end
        SW = 2'b01;
        press(CapLat + 2, CapLat + 2);
        check_eq("ignored_bus", 32'(opif.op_bus), 32'b1110);
        check_eq("ignored_valid", 32'(opif.op_valid), 32'd1);
        opif.op_ready = 1'b1;
        tick();
        opif.op_ready = 1'b0;
        check_eq("xfer_valid", 32'(opif.op_valid), 32'd0);
        check_eq("xfer_ledg", 32'(LEDG), 32'd0);
        check_eq("xfer_bus", 32'(opif.op_bus), 32'b1110);
        tick();

        // Bounce: low 3, high 2, low 3, then released.
        SW = 2'b10;
        KEY = 1'b0; repeat (3) tick();
        KEY = 1'b1; repeat (2) tick();
        KEY = 1'b0; repeat (3) tick();
        KEY = 1'b1; repeat (CapLat + 4) tick();
`ifdef OPCAP_DEBOUNCE_EN
        check_eq("bounce_ledg", 32'(LEDG), 32'd0);
`endif
        opif.op_ready = 1'b1;
        tick();
        opif.op_ready = 1'b0;
        tick();

        // Single-cycle glitch.
        SW  = 2'b01;
        KEY = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            KEY = 1'b1;
            if (LEDG[0] && lat == 0) lat = i;
        end
`ifdef OPCAP_DEBOUNCE_EN
        check_eq("glitch_rejected", 32'(lat), 32'd0);
`else
        check_eq("glitch_lat", 32'(lat), 32'd3);
`endif

        // Reset in WAIT_B while a press is mid-debounce; key held through reset.
        if (m_mode == 0) begin
            SW = 2'b11;
            press(CapLat + 2, CapLat + 2);
        end
        SW  = 2'b10;
        KEY = 1'b0;
        repeat (2) tick();
        #2 reset = 1'b1;
        m_clear();
        #1 check_reset_outputs("mid_rst");
        repeat (3) @(negedge CLOCK_50);
        #2 reset = 1'b0;
        lat = 0;
        for (int i = 1; i <= int'(CapLat) + 4; i++) begin
            tick();
            if (LEDG[0] && lat == 0) lat = i;
        end
        check_eq("lat_after_rst", 32'(lat), 32'(CapLat));
        repeat (2 * CapLat) tick();
        check_eq("single_press_ledg", 32'(LEDG), 32'b01);
        KEY = 1'b1;
        repeat (CapLat + 2) tick();

        // Randomized traffic with occasional asynchronous reset.
        run = 0;
        for (int n = 0; n < 3000; n++) begin
            if (run == 0) begin
                KEY = ~KEY;
                run = $urandom_range(1, WinLen + 3);
            end
            run--;
            SW = W'($urandom);
            opif.op_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                m_clear();
                #1 check_reset_outputs("rand_rst");
                #1 reset = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
